// File: rtl/led_blink_pkg.sv
// Shared types and defaults for the LED blink generator / meter pair.
// Latency: none (declarations only).
// Backpressure: not applicable.
package led_blink_pkg;

  // One tick is 1 ms at 100 MHz; the generator uses the same unit.
  localparam int DEFAULT_CLKS_PER_TICK = 100000;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } meter_state_t;

endpackage

// File: rtl/led_blink_meter_if.sv
// Signal bundle between a blink source/consumer and the blink meter.
// Latency: none (wiring only); min/max members exist only with LED_BLINK_METER_MINMAX_EN.
// Backpressure: none; results are pulses and levels, the consumer must keep up.
interface led_blink_meter_if #(
  parameter int CNT_W = 32
);
  logic             in_signal;
  logic             clear;
  logic [CNT_W-1:0] half_period;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
`ifdef LED_BLINK_METER_MINMAX_EN
  logic [CNT_W-1:0] min_half_period;
  logic [CNT_W-1:0] max_half_period;

  modport master (
    output in_signal, clear,
    input  half_period, meas_valid, locked, timeout, min_half_period, max_half_period
  );
  modport slave (
    input  in_signal, clear,
    output half_period, meas_valid, locked, timeout, min_half_period, max_half_period
  );
`else
  modport master (
    output in_signal, clear,
    input  half_period, meas_valid, locked, timeout
  );
  modport slave (
    input  in_signal, clear,
    output half_period, meas_valid, locked, timeout
  );
`endif
endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an async input plus a previous-value flop for edge detection.
// Latency: level follows din after 2 clk edges; toggle is high for the one cycle level changed.
// Backpressure: none; both polarities produce a single-cycle toggle.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic toggle
);
  logic ff1, ff2, ff3;

  // Metastability chain followed by the delayed copy used for edge comparison.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
      ff3 <= 1'b0;
    end else begin
      ff1 <= din;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  assign level  = ff2;
  assign toggle = ff2 ^ ff3;
endmodule

// File: rtl/led_blink_meter.sv
// Measures edge-to-edge interval of an async blink input in ticks; optional min/max via LED_BLINK_METER_MINMAX_EN.
// Latency: results appear on the clk edge after the edge-detect cycle (3 edges after input sampling).
// Backpressure: none; every edge is measured, results are one-cycle pulses.
module led_blink_meter
  import led_blink_pkg::*;
#(
  parameter int CLKS_PER_TICK = DEFAULT_CLKS_PER_TICK,
  parameter int TIMEOUT_TICKS = 10000,
  parameter int CNT_W         = 32
) (
  input logic               clk,
  input logic               reset,
  led_blink_meter_if.slave  bus
);
  localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

  logic             toggle;
  logic             level_unused;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] tick;
  logic [CNT_W-1:0] tick_next;
  logic             presc_wrap;
  meter_state_t     state, state_nxt;
  logic             take;
  logic             tmo_hit;
  logic [CNT_W-1:0] half_q;
  logic             meas_q, locked_q, tmo_q;

  sync_edge_detect u_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (bus.in_signal),
    .level  (level_unused),
    .toggle (toggle)
  );

  // tick_next is the tick count including the current cycle, i.e. floor(E / CLKS_PER_TICK)
  // when the current cycle is the E-th since the last edge.
  assign presc_wrap = (presc == PW'(CLKS_PER_TICK - 1));
  assign tick_next  = (presc_wrap && (tick != '1)) ? tick + CNT_W'(1) : tick;

  // Prescaler and saturating tick counter, restarted by every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      tick  <= '0;
    end else if (toggle) begin
      presc <= '0;
      tick  <= '0;
    end else begin
      presc <= presc_wrap ? '0 : presc + PW'(1);
      tick  <= tick_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and pulse decisions; clear beats edge, edge beats timeout.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    tmo_hit   = 1'b0;
    if (bus.clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (toggle) state_nxt = ARM;
        end
        ARM, MEASURE: begin
          if (toggle) begin
            state_nxt = MEASURE;
            take      = 1'b1;
          end else if (tick_next == CNT_W'(TIMEOUT_TICKS)) begin
            state_nxt = IDLE;
            tmo_hit   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Result, pulses and lock; the first result after IDLE (taken in ARM) never locks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_q   <= '0;
      meas_q   <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      meas_q <= take;
      tmo_q  <= tmo_hit;
      if (take) half_q <= tick_next;
      if (bus.clear || tmo_hit)
        locked_q <= 1'b0;
      else if (take)
        locked_q <= (state == MEASURE) && (tick_next == half_q);
    end
  end

  assign bus.half_period = half_q;
  assign bus.meas_valid  = meas_q;
  assign bus.locked      = locked_q;
  assign bus.timeout     = tmo_q;

`ifdef LED_BLINK_METER_MINMAX_EN
  logic [CNT_W-1:0] min_q, max_q;

  // Running extremes; the all-ones/zero start makes the first result set both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_q <= '1;
      max_q <= '0;
    end else if (bus.clear) begin
      min_q <= '1;
      max_q <= '0;
    end else if (take) begin
      if (tick_next < min_q) min_q <= tick_next;
      if (tick_next > max_q) max_q <= tick_next;
    end
  end

  assign bus.min_half_period = min_q;
  assign bus.max_half_period = max_q;
`endif
endmodule

// File: tb/tb_led_blink_meter.sv
// Self-checking bench for led_blink_meter with CLKS_PER_TICK=10, TIMEOUT_TICKS=20.
// Latency: expected results queued at drive time, popped when meas_valid appears.
// Backpressure: none; monitor samples on the falling clock edge.
module tb_led_blink_meter;
  localparam int CPT   = 10;
  localparam int TMO   = 20;
  localparam int CNT_W = 32;

  typedef struct {
    int gap;
    bit exp_meas;
    int exp_hp;
    bit exp_lock;
  } vec_t;

  typedef struct {
    int hp;
    bit lock;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   last_meas_cyc;
  int   tmo_cyc;
  int   tmo_count;
  exp_t exp_q[$];
  vec_t vecs[14];

  led_blink_meter_if #(.CNT_W(CNT_W)) bus ();

  led_blink_meter #(
    .CLKS_PER_TICK (CPT),
    .TIMEOUT_TICKS (TMO),
    .CNT_W         (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic edge_after(input int gap);
    cyc_wait(gap);
    bus.in_signal = ~bus.in_signal;
  endtask

  task automatic push_exp(input int hp, input bit lock);
    exp_t e;
    e.hp   = hp;
    e.lock = lock;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every meas_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.meas_valid) begin
        last_meas_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_meas: got meas_valid with half_period=%0d, expected none",
                   bus.half_period);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("meas_half_period", 64'(bus.half_period), 64'(e.hp));
          chk("meas_locked", 64'(bus.locked), 64'(e.lock));
        end
      end
      if (bus.timeout) begin
        tmo_count++;
        tmo_cyc = cyc;
      end
    end
  end

  initial begin
    int bad;
    checks = 0;
    errors = 0;
    cyc = 0;
    last_meas_cyc = 0;
    tmo_cyc = 0;
    tmo_count = 0;

    //            gap  meas hp lock
    vecs[0]  = '{5,  1'b0, 0, 1'b0};  // arm from IDLE
    vecs[1]  = '{50, 1'b1, 5, 1'b0};  // first result never locks
    vecs[2]  = '{50, 1'b1, 5, 1'b1};
    vecs[3]  = '{73, 1'b1, 7, 1'b0};  // changed value drops lock
    vecs[4]  = '{73, 1'b1, 7, 1'b1};
    vecs[5]  = '{9,  1'b1, 0, 1'b0};  // zero-tick interval
    vecs[6]  = '{9,  1'b1, 0, 1'b1};
    vecs[7]  = '{1,  1'b1, 0, 1'b1};  // edges every cycle
    vecs[8]  = '{1,  1'b1, 0, 1'b1};
    vecs[9]  = '{10, 1'b1, 1, 1'b0};  // exact tick boundary
    vecs[10] = '{19, 1'b1, 1, 1'b1};
    vecs[11] = '{20, 1'b1, 2, 1'b0};
    vecs[12] = '{73, 1'b1, 7, 1'b0};
    vecs[13] = '{73, 1'b1, 7, 1'b1};

    rst_n = 1'b0;
    bus.in_signal = 1'b0;
    bus.clear = 1'b0;
    cyc_wait(3);
    chk("reset_half_period", 64'(bus.half_period), 64'd0);
    chk("reset_meas_valid", 64'(bus.meas_valid), 64'd0);
    chk("reset_locked", 64'(bus.locked), 64'd0);
    chk("reset_timeout", 64'(bus.timeout), 64'd0);
    rst_n = 1'b1;

    // Idle input: nothing may move, and IDLE has no timeout.
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.meas_valid || bus.locked || bus.timeout || (bus.half_period != 0)) bad++;
    end
    chk("idle_outputs_quiet", 64'(bad), 64'd0);
    chk("idle_no_timeout", 64'(tmo_count), 64'd0);
    cyc_wait(1);

    for (int i = 0; i < 14; i++) begin
      edge_after(vecs[i].gap);
      if (vecs[i].exp_meas) push_exp(vecs[i].exp_hp, vecs[i].exp_lock);
    end

    // Input stops: exactly one timeout, 200 cycles after the last result.
    for (int k = 0; k < 400 && tmo_count == 0; k++) @(negedge clk);
    chk("timeout_seen", 64'(tmo_count), 64'd1);
    chk("timeout_delay", 64'(tmo_cyc - last_meas_cyc), 64'd200);
    repeat (300) @(negedge clk);
    chk("timeout_once", 64'(tmo_count), 64'd1);
    chk("timeout_locked", 64'(bus.locked), 64'd0);
    chk("timeout_hp_hold", 64'(bus.half_period), 64'd7);
    cyc_wait(1);

    // After timeout the next edge only arms.
    edge_after(50);
    edge_after(50);
    push_exp(5, 1'b0);
    edge_after(50);
    push_exp(5, 1'b1);
    cyc_wait(10);
    chk("relock_locked", 64'(bus.locked), 64'd1);

    // clear in the same cycle as the detected edge: no result, lock dropped.
    edge_after(40);
    cyc_wait(2);
    bus.clear = 1'b1;
    cyc_wait(1);
    bus.clear = 1'b0;
    cyc_wait(5);
    chk("clear_locked", 64'(bus.locked), 64'd0);
    chk("clear_hp_hold", 64'(bus.half_period), 64'd5);
    edge_after(50);
    edge_after(50);
    push_exp(5, 1'b0);
    edge_after(50);
    push_exp(5, 1'b1);
    edge_after(30);
    push_exp(3, 1'b0);
    edge_after(90);
    push_exp(9, 1'b0);
    cyc_wait(20);
`ifdef LED_BLINK_METER_MINMAX_EN
    chk("pre_reset_min", 64'(bus.min_half_period), 64'd3);
    chk("pre_reset_max", 64'(bus.max_half_period), 64'd9);
`endif

    // Async reset mid-interval, away from any clock edge.
    #3;
    rst_n = 1'b0;
    bus.in_signal = 1'b0;
    #1;
    chk("areset_half_period", 64'(bus.half_period), 64'd0);
    chk("areset_locked", 64'(bus.locked), 64'd0);
    chk("areset_meas_valid", 64'(bus.meas_valid), 64'd0);
    chk("areset_timeout", 64'(bus.timeout), 64'd0);
`ifdef LED_BLINK_METER_MINMAX_EN
    chk("areset_min", 64'(bus.min_half_period), 64'(32'hFFFF_FFFF));
    chk("areset_max", 64'(bus.max_half_period), 64'd0);
`endif
    cyc_wait(3);
    rst_n = 1'b1;
    cyc_wait(2);
    edge_after(5);
    edge_after(40);
    push_exp(4, 1'b0);
    edge_after(60);
    push_exp(6, 1'b0);
    cyc_wait(10);
`ifdef LED_BLINK_METER_MINMAX_EN
    chk("post_reset_min", 64'(bus.min_half_period), 64'd4);
    chk("post_reset_max", 64'(bus.max_half_period), 64'd6);
`endif
    chk("post_reset_hp", 64'(bus.half_period), 64'd6);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_blink_meter.md
Name: led_blink_meter

Overview:
- Receive-side counterpart to the LED blink generator: measures the toggle interval of an incoming square-wave/blink signal.
- Reports the interval in the same tick units the generator's upper bound uses (1 tick = CLKS_PER_TICK clk cycles; 100000 = 1 ms at 100 MHz).
- Used for loopback self-test of blink outputs and for reading external blink/heartbeat inputs.

Parameters:
- CLKS_PER_TICK, 100000, clk cycles per measurement tick.
- TIMEOUT_TICKS, 10000, ticks without an edge before the measurement is declared lost.
- CNT_W, 32, width of tick counter and result.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_signal  in  1  asynchronous blink input, double-flop synchronised internally
- clear  in  1  synchronous: abort measurement, return to IDLE, drop lock
- half_period  out  CNT_W  last measured edge-to-edge interval, in ticks (floor)
- meas_valid  out  1  one-cycle pulse when half_period updates
- locked  out  1  two consecutive identical measurements seen
- timeout  out  1  one-cycle pulse when TIMEOUT_TICKS elapse with no edge

Behaviour:
- Reset (reset=0, async): all outputs 0; synchroniser flops 0; FSM=IDLE; prescaler and tick counter 0.
- Input path: ff1<-in_signal, ff2<-ff1, ff3<-ff2; edge = ff2 XOR ff3. Both polarities count.
- Prescaler: 0..CLKS_PER_TICK-1. On wrap, tick_cnt increments, saturating at 2^CNT_W-1. On every edge, both reset so that the cycle after the edge is elapsed cycle 1.
- Measured value: floor(E / CLKS_PER_TICK), where E = clk cycles between consecutive edge cycles. A generator toggling every N*CLKS_PER_TICK cycles yields exactly N.
- FSM:
  - IDLE: wait for edge. Edge -> ARM; counters cleared; no output.
  - ARM: first interval in progress. Edge -> MEASURE; result registered; meas_valid pulses.
  - MEASURE: each edge -> result registered; meas_valid pulses.
  - ARM or MEASURE: tick_cnt reaching TIMEOUT_TICKS with no edge -> IDLE; timeout pulses; locked cleared; half_period holds its last value.
- Latency: meas_valid and half_period update on the clk edge after the edge-detect cycle. That is 3 rising clk edges after in_signal is first sampled at its new level.
- Lock:
  - Set on a valid result equal to the previous valid result.
  - Cleared on an unequal result, timeout, clear, or reset.
  - The first result after IDLE never sets lock.
- Edge coincident with timeout count: the edge wins; measurement is taken, no timeout pulse.
- clear:
  - Has priority over edge and timeout in the same cycle.
  - Next state IDLE, locked=0, no pulses; half_period holds.
- Zero-tick interval (E < CLKS_PER_TICK): reported as 0, meas_valid still pulses. Lock compares as normal.
- Edges arriving every cycle are all measured; there is no minimum spacing.

Optional Feature:
- LED_BLINK_METER_MINMAX_EN
- Defined: adds outputs min_half_period and max_half_period (CNT_W each).
  - Updated on each meas_valid.
  - Reset/clear: min = all-ones, max = 0.
  - The first valid result after clear or reset sets both.
  - Timeout does not reset them.
- Undefined: ports and registers absent; all other behaviour identical.

Decomposition:
- Package led_blink_pkg:
  - typedef enum meter_state_t {IDLE, ARM, MEASURE}.
  - localparam default CLKS_PER_TICK = 100000, shared with the blink generator.
- Sub-module: sync_edge_detect (2-flop synchroniser + previous-value flop; outputs level and edge). Reusable for other async inputs.

Test Plan (CLKS_PER_TICK=10, TIMEOUT_TICKS=20):
- Reset release, in_signal idle 0 -> outputs 0 for 500 cycles; timeout never pulses (IDLE has no timeout).
- in_signal toggles every 50 cycles -> first meas_valid after the second edge with half_period=5; locked=1 after the third edge.
- Interval changes to 73 cycles -> half_period=7; locked drops on the first changed value and re-asserts on the next.
- Toggling stops after lock -> timeout pulses exactly once 200 cycles after the last edge; locked=0; state IDLE; half_period holds 7.
- clear asserted in the same cycle as a detected edge -> no meas_valid, locked=0; the next edge only re-arms.
- Async reset asserted mid-interval, with the minmax macro defined and earlier results 3 and 9 -> all outputs 0 immediately, min=all-ones, max=0. After reset release, measured intervals of 4 then 6 give min=4, max=6.
